// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module     : pc_sequencer
//  Description: Program counter owner and single-outstanding instruction fetch
//               sequencer with branch redirect, flush pulse and redirect count.
//  Revision   : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic             br_write,
    input  logic [31:0]      br_target,
    input  logic             stall,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    output logic             flush,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_pc_q;
    logic             instr_valid_q, flush_q, misalign_q;
    logic [CNT_W-1:0] cnt_q;

    logic w_taken, w_redirect, w_misalign, w_accept, w_capture;

    assign w_taken    = br_valid & br_write;
    assign w_redirect = w_taken & (br_target[1:0] == 2'b00);
    assign w_misalign = w_taken & (br_target[1:0] != 2'b00);
    assign w_accept   = (state_q == S_FETCH) & imem_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        w_capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_redirect || !stall) state_d = S_FETCH;
            end
            S_FETCH: begin
                // An accepted request on a redirect cycle still owes us a response.
                if (w_accept) state_d = w_redirect ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (w_redirect) begin
                    state_d = imem_rsp_valid ? S_FETCH : S_DROP;
                end else if (imem_rsp_valid) begin
                    w_capture = 1'b1;
                    pc_d      = pc_q + 32'd4;
                    state_d   = stall ? S_IDLE : S_FETCH;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
        if (w_redirect) pc_d = br_target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_VECTOR;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= w_capture;
            flush_q       <= w_redirect;
            if (w_capture) begin
                instr_q    <= imem_rsp_data;
                instr_pc_q <= pc_q;
            end
            if (w_misalign) misalign_q <= 1'b1;
            if (w_redirect && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign imem_req     = (state_q == S_FETCH);
    assign imem_addr    = pc_q;
    assign instr_valid  = instr_valid_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign flush        = flush_q;
    assign misalign_err = misalign_q;
    assign redirect_cnt = cnt_q;

endmodule
`default_nettype wire
